// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program loader.
// LOADER_CHECKSUM_EN adds the CHK state used for the trailing checksum byte.
package loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
`ifdef LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE,
        S_ERR
    } state_t;

    localparam int HDR_BYTES  = 2;
    localparam int WORD_BYTES = 4;

    // A load is in flight in every state except the three resting ones.
    function automatic logic is_active(input state_t s);
        return !(s == S_IDLE || s == S_DONE || s == S_ERR);
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream and instruction-memory link between the boot host and prog_loader.
interface prog_loader_if #(parameter int ADDR_W = 8);
    logic              start;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_reset;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, rx_valid, rx_data,
        input  rx_ready, imem_we, imem_addr, imem_wdata, cpu_reset, busy, done, err
    );

    modport slave (
        input  start, rx_valid, rx_data,
        output rx_ready, imem_we, imem_addr, imem_wdata, cpu_reset, busy, done, err
    );
endinterface

// File: rtl/prog_loader_word_assembler.sv
// Packs accepted bytes MSB-first into 32-bit words; word_valid marks the 4th byte.
module word_assembler
    import loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_valid
);
    localparam int CNT_W = $clog2(WORD_BYTES);

    logic [CNT_W-1:0] cnt;
    logic [23:0]      shreg;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            cnt   <= '0;
            shreg <= '0;
        end else if (byte_en) begin
            cnt   <= cnt + 1'b1;
            shreg <= {shreg[15:0], byte_in};
        end
    end

    // The completed word includes the byte arriving this cycle.
    assign word_valid = byte_en && (cnt == CNT_W'(WORD_BYTES - 1));
    assign word       = {shreg, byte_in};
endmodule

// File: rtl/prog_loader.sv
// Boot loader: length-prefixed byte stream -> instruction memory, holds the CPU in reset until done.
// LOADER_CHECKSUM_EN enables a trailing XOR checksum byte verified in the CHK state.
module prog_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input logic          clock,
    input logic          reset,
    prog_loader_if.slave bus
);
    localparam logic [16:0] CAPACITY = 17'(1) << ADDR_W;
`ifdef LOADER_CHECKSUM_EN
    localparam state_t FINAL = S_CHK;
`else
    localparam state_t FINAL = S_DONE;
`endif

    state_t            state, nxt;
    logic [ADDR_W-1:0] waddr;
    logic [15:0]       words_left;
    logic [7:0]        len_hi;
    logic [16:0]       len_in;
    logic              accept, asm_clear, asm_en, word_valid;
    logic [31:0]       word;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        chk;
`endif

    assign accept    = bus.rx_valid && bus.rx_ready;
    assign asm_clear = bus.start && !is_active(state);
    assign asm_en    = accept && (state == S_DATA);
    assign len_in    = {1'b0, len_hi, bus.rx_data};

    word_assembler u_asm (
        .clock      (clock),
        .reset      (reset),
        .clear      (asm_clear),
        .byte_en    (asm_en),
        .byte_in    (bus.rx_data),
        .word       (word),
        .word_valid (word_valid)
    );

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: if (bus.start) nxt = S_LEN_HI;
            S_LEN_HI: if (accept) nxt = S_LEN_LO;
            S_LEN_LO: if (accept) begin
                if (len_in > CAPACITY)    nxt = S_ERR;
                else if (len_in == 17'd0) nxt = FINAL;
                else                      nxt = S_DATA;
            end
            S_DATA: if (word_valid && words_left == 16'd1) nxt = FINAL;
`ifdef LOADER_CHECKSUM_EN
            S_CHK: if (accept) nxt = (bus.rx_data == chk) ? S_DONE : S_ERR;
`endif
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= S_IDLE;
            waddr          <= '0;
            words_left     <= '0;
            len_hi         <= '0;
`ifdef LOADER_CHECKSUM_EN
            chk            <= '0;
`endif
            bus.rx_ready   <= 1'b0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
            bus.cpu_reset  <= 1'b1;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.err        <= 1'b0;
        end else begin
            bus.imem_we <= 1'b0;
            if (asm_clear) begin
                waddr <= '0;
`ifdef LOADER_CHECKSUM_EN
                chk   <= '0;
`endif
            end
            if (state == S_LEN_HI && accept) len_hi <= bus.rx_data;
            if (state == S_LEN_LO && accept) words_left <= len_in[15:0];
`ifdef LOADER_CHECKSUM_EN
            if (accept && state != S_CHK) chk <= chk ^ bus.rx_data;
`endif
            if (word_valid) begin
                bus.imem_we    <= 1'b1;
                bus.imem_addr  <= waddr;
                bus.imem_wdata <= word;
                waddr          <= waddr + 1'b1;
                words_left     <= words_left - 16'd1;
            end
            // Status outputs follow the state being entered so they are valid in its first cycle.
            state         <= nxt;
            bus.rx_ready  <= is_active(nxt);
            bus.busy      <= is_active(nxt);
            bus.cpu_reset <= (nxt != S_DONE);
            bus.done      <= (nxt == S_DONE);
            bus.err       <= (nxt == S_ERR);
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: streams drive a word-level model, a monitor checks every write.
module tb_prog_loader;
    import loader_pkg::*;

    localparam int ADDR_W = 8;
    localparam int CAP    = 1 << ADDR_W;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    prog_loader_if #(.ADDR_W(ADDR_W)) bus ();
    prog_loader #(.ADDR_W(ADDR_W)) dut (.clock(clock), .reset(reset), .bus(bus));

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] words[$];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (reset === 1'b0 && bus.imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0h data %0h, expected no write",
                         bus.imem_addr, bus.imem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(bus.imem_addr), 32'(e.addr));
                check("wr_data", bus.imem_wdata, e.data);
            end
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_rx_ready"},   32'(bus.rx_ready),  0);
        check({tag, "_imem_we"},    32'(bus.imem_we),   0);
        check({tag, "_imem_addr"},  32'(bus.imem_addr), 0);
        check({tag, "_imem_wdata"}, bus.imem_wdata,     0);
        check({tag, "_cpu_reset"},  32'(bus.cpu_reset), 1);
        check({tag, "_busy"},       32'(bus.busy),      0);
        check({tag, "_done"},       32'(bus.done),      0);
        check({tag, "_err"},        32'(bus.err),       0);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit rnd);
        int budget;
        if (rnd) begin
            if ($urandom_range(0, 7) == 0) pulse_start();
            repeat ($urandom_range(0, 2)) begin
                bus.rx_valid = 1'b0;
                @(negedge clock);
            end
        end
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        budget = 0;
        while (bus.rx_ready !== 1'b1 && budget < 20) begin
            @(negedge clock);
            budget++;
        end
        if (bus.rx_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL byte_timeout: rx_ready=%b, required 1 within 20 cycles", bus.rx_ready);
        end
        @(negedge clock);
        bus.rx_valid = 1'b0;
    endtask

    task automatic fill_random(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back($urandom);
    endtask

    // Model: a legal length yields writes of words[0..n-1] at addresses 0..n-1 and DONE.
    task automatic run_stream(input int n, input bit rnd, input bit bad_chk);
        logic [15:0] n16;
        logic [7:0]  x;
        bit          exp_err;
        int          budget;
        n16 = 16'(n);
        pulse_start();
        check("start_busy",     32'(bus.busy),     1);
        check("start_rx_ready", 32'(bus.rx_ready), 1);
        x = n16[15:8] ^ n16[7:0];
        send_byte(n16[15:8], rnd);
        send_byte(n16[7:0], rnd);
        exp_err = (n > CAP);
        if (!exp_err) begin
            for (int i = 0; i < n; i++) begin
                logic [31:0] w;
                w = words[i];
                exp_q.push_back('{addr: ADDR_W'(i), data: w});
                for (int k = 3; k >= 0; k--) begin
                    x ^= w[8*k +: 8];
                    send_byte(w[8*k +: 8], rnd);
                end
            end
`ifdef LOADER_CHECKSUM_EN
            send_byte(bad_chk ? (x ^ 8'h01) : x, rnd);
            exp_err = bad_chk;
`else
            if (bad_chk) exp_err = 1'b0;
`endif
        end
        budget = 0;
        while (!(bus.done === 1'b1 || bus.err === 1'b1) && budget < 10) begin
            @(negedge clock);
            budget++;
        end
        check("end_done",      32'(bus.done),      32'(!exp_err));
        check("end_err",       32'(bus.err),       32'(exp_err));
        check("end_cpu_reset", 32'(bus.cpu_reset), 32'(exp_err));
        check("end_busy",      32'(bus.busy),      0);
        check("end_rx_ready",  32'(bus.rx_ready),  0);
        repeat (2) @(negedge clock);
        check("writes_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int n;
        bus.start    = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        reset        = 1'b1;
        repeat (3) @(negedge clock);
        check_reset_values("por");
        reset = 1'b0;
        @(negedge clock);
        check("idle_cpu_reset", 32'(bus.cpu_reset), 1);

        words = '{32'h3C000003, 32'h3C210005};
        run_stream(2, 1'b0, 1'b0);

        words.delete();
        run_stream(0, 1'b0, 1'b0);

        run_stream(257, 1'b0, 1'b0);

        // Reset after the 2nd data byte, then a clean reload from address 0.
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h3C, 1'b0);
        send_byte(8'h00, 1'b0);
        reset = 1'b1;
        @(negedge clock);
        check_reset_values("midload");
        reset = 1'b0;
        @(negedge clock);
        words = '{32'h3C000003, 32'h3C210005};
        run_stream(2, 1'b0, 1'b0);

`ifdef LOADER_CHECKSUM_EN
        words = '{32'h00000020};
        run_stream(1, 1'b0, 1'b0);
        run_stream(1, 1'b0, 1'b1);
`endif

        words = '{32'h3C000003, 32'h3C210005};
        run_stream(2, 1'b1, 1'b0);

        fill_random(CAP);
        run_stream(CAP, 1'b0, 1'b0);

        for (int t = 0; t < 12; t++) begin
            n = $urandom_range(0, 12);
            if ($urandom_range(0, 5) == 0) n = CAP + $urandom_range(1, 40);
            fill_random(n);
            run_stream(n, 1'b1, $urandom_range(0, 3) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/prog_loader.md
# prog_loader

Upstream boot stage for the single-cycle MIPS core. It receives a program as a byte stream over a valid/ready link and assembles big-endian 32-bit words. Each word is written into consecutive instruction-memory locations starting at word 0. The core's `reset` is held asserted until a complete, valid image has been written, so the CPU only ever fetches a fully loaded program.

## Interface
Parameters:
- `ADDR_W`, 8, instruction-memory word-address width; capacity `2**ADDR_W` words

Ports:
- `clock`  in  1  system clock; all state changes on the rising edge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  one-cycle request to begin a load; honoured only in IDLE, DONE or ERR
- `rx_valid`  in  1  byte available on `rx_data`
- `rx_data`  in  8  stream byte
- `rx_ready`  out  1  loader can accept a byte
- `imem_we`  out  1  instruction-memory write strobe, one cycle per word
- `imem_addr`  out  ADDR_W  word address of the write
- `imem_wdata`  out  32  word to write
- `cpu_reset`  out  1  drives the MIPS core reset
- `busy`  out  1  load in progress
- `done`  out  1  image loaded successfully; sticky
- `err`  out  1  load aborted; sticky

## Operation
- Stream format:
  - `LEN_HI`, then `LEN_LO`: 16-bit word count N, big-endian.
  - Then N words, 4 bytes each, MSB first.
  - Then one checksum byte, only when the checksum feature is compiled in.
- A byte is accepted only on a cycle with `rx_valid && rx_ready`.
- FSM states: IDLE, LEN_HI, LEN_LO, DATA, CHK (present only when the checksum feature is compiled in), DONE, ERR.
  - IDLE/DONE/ERR + `start` -> LEN_HI. This clears `done`/`err` and zeroes the word address, byte counter and checksum.
  - LEN_HI + byte accepted -> LEN_LO.
  - LEN_LO + byte accepted:
    - N > `2**ADDR_W` -> ERR.
    - N == 0 -> CHK (checksum build) or DONE (no checksum).
    - Otherwise -> DATA.
  - DATA: a 2-bit byte counter shifts bytes into a 32-bit assembler.
    - After the 4th byte of a word, a write is issued and the word address increments.
    - After the 4th byte of word N-1 -> CHK or DONE.
  - CHK + byte accepted: byte == running checksum -> DONE, else -> ERR.
- Address arithmetic:
  - `imem_addr` is the modulo-`2**ADDR_W` word index.
  - The length check guarantees no wrap occurs during a legal load.
- `start` in LEN_HI, LEN_LO, DATA or CHK is ignored.
- Output values by state:
  - `rx_ready` = 1 in LEN_HI, LEN_LO, DATA, CHK; 0 otherwise.
  - `busy` = 1 in LEN_HI, LEN_LO, DATA, CHK.
  - `cpu_reset` = 0 only in DONE; 1 in every other state, including ERR.

## Timing
- Reset values:
  - State IDLE.
  - `rx_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0.
  - `cpu_reset`=1, `busy`=0, `done`=0, `err`=0.
- `reset` asserted mid-load aborts immediately to the reset values. A partial image remains in memory; the CPU stays held.
- `start` is sampled in cycle t; `rx_ready`=1 from cycle t+1.
- Word write latency:
  - `imem_we`, `imem_addr` and `imem_wdata` are registered.
  - The write strobe is high for exactly the one cycle after the 4th byte of a word is accepted.
  - `imem_addr` holds the index of that word during the strobe.
- Back-to-back bytes at full rate are supported: `rx_ready` never drops inside DATA.
- DONE/ERR are entered on the cycle after the final byte is accepted. For the last word, this coincides with its `imem_we` cycle.
- `cpu_reset` falls and `done` rises in the first DONE cycle.

## Configuration
- `LOADER_CHECKSUM_EN` defined:
  - The CHK state and an 8-bit running XOR are built.
  - The XOR covers all accepted bytes: both length bytes and all data bytes.
  - The stream carries a trailing checksum byte; a mismatch leads to ERR.
- Not defined:
  - No CHK state and no checksum byte in the stream.
  - ERR is reachable only through length overflow.

## Structure
- Shared package `loader_pkg` holds:
  - the state enumeration;
  - the header length constant (2 bytes);
  - the bytes-per-word constant (4).
- Sub-module `word_assembler` holds:
  - the 32-bit byte shift register;
  - the 2-bit byte counter;
  - a `word_valid` pulse on the 4th byte.
- FSM, address counter and checksum stay in `prog_loader`.

## Test plan
- Reset, then stream 00 02 | 3C000003 | 3C210005 at full rate:
  - `imem_we` pulses at addr 0 with 3C000003, then at addr 1 with 3C210005.
  - `done`=1, `cpu_reset`=0.
- Stream 00 00 (no checksum build) -> DONE with zero writes, `cpu_reset`=0.
- `ADDR_W`=8, stream 01 01 -> ERR after the 2nd byte; `cpu_reset`=1, no writes.
- Assert `reset` after the 2nd data byte -> all outputs at reset values. Next `start` plus a full stream loads correctly from addr 0.
- Checksum build: stream 00 01 | 00000020 | 21 -> DONE. The same stream with trailing byte 20 -> ERR with `err`=1.
- Toggle `rx_valid` randomly and pulse `start` mid-load -> same writes as the full-rate run; `start` ignored.
